// File: rtl/lab7_button_servicer.sv
// Hardware servicer for the pushbutton PIO edge-capture interrupt: programs irq_mask
// after reset, then on each irq reads and write-clears edge_capture and updates the LEDs.
module lab7_button_servicer #(
  parameter int unsigned           WIDTH     = 4,
  parameter logic [WIDTH-1:0]      INIT_MASK = WIDTH'(4'hF)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             led_clear,
  input  logic             irq,
  input  logic [31:0]      readdata,
  output logic [1:0]       address,
  output logic             chipselect,
  output logic             write_n,
  output logic [31:0]      writedata,
  output logic [WIDTH-1:0] led,
  output logic [15:0]      event_count,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_START,
    S_INIT_WR,
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_CLR_WR,
    S_APPLY
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] cap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_START;
      cap         <= '0;
      led         <= '0;
      event_count <= '0;
    end else begin
      case (state)
        S_START:   state <= S_INIT_WR;
        S_INIT_WR: state <= S_IDLE;
        S_IDLE:    state <= (enable && irq) ? S_RD_ADDR : S_IDLE;
        S_RD_ADDR: state <= S_RD_DATA;
        S_RD_DATA: state <= S_CLR_WR;
        S_CLR_WR:  state <= S_APPLY;
        S_APPLY:   state <= S_IDLE;
        default:   state <= S_START;
      endcase

      // Slave read latency is one cycle, so edge_capture is on readdata during RD_DATA.
      if (state == S_RD_DATA)
        cap <= readdata[WIDTH-1:0];

      if (state == S_APPLY && cap != '0) begin
        led <= mode ? cap : (led ^ cap);
        if (event_count != '1)
          event_count <= event_count + 16'd1;
      end

      // Clear wins over a coincident APPLY update.
      if (led_clear)
        led <= '0;
    end
  end

  always_comb begin
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    case (state)
      S_INIT_WR: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd2;
        writedata  = 32'(INIT_MASK);
      end
      S_RD_ADDR, S_RD_DATA: begin
        chipselect = 1'b1;
        address    = 2'd3;
      end
      S_CLR_WR: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'd3;
        writedata  = 32'(cap);
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_lab7_button_servicer.sv
// Directed bench for lab7_button_servicer with a small pushbutton PIO slave model.
module tb_lab7_button_servicer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        mode;
  logic        led_clear;
  logic        irq;
  logic [31:0] readdata;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  led;
  logic [15:0] event_count;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [3:0]  press;
  logic        force_irq;
  logic [27:0] rd_upper;
  logic [3:0]  edge_cap;
  logic [3:0]  irq_mask;
  logic [31:0] pio_rd;

  lab7_button_servicer #(.WIDTH(4), .INIT_MASK(4'h5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .mode        (mode),
    .led_clear   (led_clear),
    .irq         (irq),
    .readdata    (readdata),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .led         (led),
    .event_count (event_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // PIO slave model: registered readdata, write-to-clear edge capture with clear priority.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= 4'h0;
      irq_mask <= 4'h0;
      pio_rd   <= 32'h0;
    end else begin
      if (chipselect && !write_n && address == 2'd2)
        irq_mask <= writedata[3:0];
      pio_rd <= (chipselect && write_n && address == 2'd3) ? {rd_upper, edge_cap} : 32'h0;
      if (chipselect && !write_n && address == 2'd3)
        edge_cap <= edge_cap & ~writedata[3:0];
      else
        edge_cap <= edge_cap | press;
    end
  end

  assign irq      = force_irq | (|edge_cap);
  assign readdata = pio_rd;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bus(input logic cs, input logic wn, input logic [1:0] a,
                                      input logic [31:0] wd);
    return 64'({cs, wn, a, wd});
  endfunction

  task automatic chk_bus(input string tag, input logic [63:0] exp);
    chk(tag, 64'({chipselect, write_n, address, writedata}), exp);
  endtask

  // One complete service, starting from IDLE at a negedge.
  task automatic service(input string tag, input logic [3:0] btn, input logic spurious,
                         input logic clr, input logic [3:0] exp_led, input logic [15:0] exp_ev);
    if (spurious) force_irq = 1'b1;
    else          press     = btn;
    tick;
    press = 4'h0;
    if (!spurious) begin
      chk({tag, "_irq"}, 64'(irq), 64'd1);
      chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
      tick;
    end
    force_irq = 1'b0;
    chk_bus({tag, "_rd_addr"}, bus(1'b1, 1'b1, 2'd3, 32'h0));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    tick;
    chk_bus({tag, "_rd_data"}, bus(1'b1, 1'b1, 2'd3, 32'h0));
    tick;
    chk_bus({tag, "_clr_wr"}, bus(1'b1, 1'b0, 2'd3, 32'(spurious ? 4'h0 : btn)));
    tick;
    chk_bus({tag, "_apply"}, bus(1'b0, 1'b1, 2'd0, 32'h0));
    led_clear = clr;
    tick;
    led_clear = 1'b0;
    chk({tag, "_led"}, 64'(led), 64'(exp_led));
    chk({tag, "_ev"}, 64'(event_count), 64'(exp_ev));
    chk({tag, "_done_busy"}, 64'(busy), 64'd0);
    chk({tag, "_irq_low"}, 64'(irq), 64'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    mode      = 1'b0;
    led_clear = 1'b0;
    press     = 4'h0;
    force_irq = 1'b0;
    rd_upper  = 28'h0;

    tick;
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_led", 64'(led), 64'd0);
    chk("rst_ev", 64'(event_count), 64'd0);
    chk_bus("rst_bus", bus(1'b0, 1'b1, 2'd0, 32'h0));

    reset_n = 1'b1;
    enable  = 1'b1;
    chk_bus("start_bus", bus(1'b0, 1'b1, 2'd0, 32'h0));
    tick;
    chk_bus("init_wr", bus(1'b1, 1'b0, 2'd2, 32'h5));
    tick;
    chk_bus("idle_bus", bus(1'b0, 1'b1, 2'd0, 32'h0));
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_led", 64'(led), 64'd0);
    chk("mask_prog", 64'(irq_mask), 64'h5);

    service("btn1_a", 4'h2, 1'b0, 1'b0, 4'h2, 16'd1);
    service("btn1_b", 4'h2, 1'b0, 1'b0, 4'h0, 16'd2);
    service("btnA",   4'hA, 1'b0, 1'b0, 4'hA, 16'd3);

    mode     = 1'b1;
    rd_upper = 28'hFFFFFFF;
    service("load9",  4'h9, 1'b0, 1'b0, 4'h9, 16'd4);
    service("spur",   4'h0, 1'b1, 1'b0, 4'h9, 16'd4);

    mode     = 1'b0;
    rd_upper = 28'h0;
    service("clr",    4'h4, 1'b0, 1'b1, 4'h0, 16'd5);

    enable    = 1'b0;
    force_irq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_bus("dis_bus", bus(1'b0, 1'b1, 2'd0, 32'h0));
      chk("dis_busy", 64'(busy), 64'd0);
    end
    force_irq = 1'b0;
    enable    = 1'b1;
    tick;

    force dut.event_count = 16'hFFFE;
    #1;
    release dut.event_count;
    tick;
    service("sat_a",  4'h1, 1'b0, 1'b0, 4'h1, 16'hFFFF);
    service("sat_b",  4'h1, 1'b0, 1'b0, 4'h0, 16'hFFFF);
    service("post",   4'h8, 1'b0, 1'b0, 4'h8, 16'hFFFF);

    // Reset asserted while the servicer sits in RD_DATA.
    press = 4'h2;
    tick;
    press = 4'h0;
    tick;
    tick;
    chk_bus("pre_rst_rd_data", bus(1'b1, 1'b1, 2'd3, 32'h0));
    reset_n = 1'b0;
    #1;
    chk("arst_led", 64'(led), 64'd0);
    chk("arst_ev", 64'(event_count), 64'd0);
    chk("arst_busy", 64'(busy), 64'd1);
    chk_bus("arst_bus", bus(1'b0, 1'b1, 2'd0, 32'h0));
    tick;
    reset_n = 1'b1;
    chk_bus("rel_start", bus(1'b0, 1'b1, 2'd0, 32'h0));
    tick;
    chk_bus("rel_init_wr", bus(1'b1, 1'b0, 2'd2, 32'h5));
    tick;
    chk("rel_idle_busy", 64'(busy), 64'd0);
    chk("rel_idle_led", 64'(led), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lab7_button_servicer.md
Name: lab7_button_servicer

Overview:
- Avalon-MM master that services the pushbutton PIO slave's edge-capture interrupt in hardware. No Nios involvement.
- On reset exit it programs the PIO irq_mask.
- On each irq it reads edge_capture, write-clears it, and applies the captured bits to an LED register. It also counts serviced events.
- Sits between the pushbutton PIO s1 port and the LED outputs of the light-driver.

Parameters:
- WIDTH, 4, number of buttons and LEDs; legal range 1..32.
- INIT_MASK, 4'hF, value written to PIO irq_mask (address 2) after reset; WIDTH bits wide, zero-extended to 32.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  when 1, IDLE may start a service.
- mode  input  1  0 = toggle LEDs by captured bits; 1 = load LEDs with captured bits.
- led_clear  input  1  synchronous LED clear.
- irq  input  1  PIO interrupt.
- readdata  input  32  PIO readdata; registered in the slave, so fixed read latency is 1.
- address  output  2  PIO address.
- chipselect  output  1  PIO chipselect.
- write_n  output  1  PIO write, active-low.
- writedata  output  32  PIO writedata.
- led  output  WIDTH  LED register.
- event_count  output  16  saturating count of non-empty services.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- The interface uses reset reset_n, asynchronous, active-low; clock clk.
- Bus outputs are decoded from the state register only; no input feeds them combinationally.
- Per-state bus outputs:
  - START: cs=0, wr_n=1, addr=0, wdata=0.
  - INIT_WR: cs=1, wr_n=0, addr=2, wdata=INIT_MASK.
  - IDLE: same as START.
  - RD_ADDR: cs=1, wr_n=1, addr=3, wdata=0.
  - RD_DATA: same as RD_ADDR.
  - CLR_WR: cs=1, wr_n=0, addr=3, wdata=zero-extended cap.
  - APPLY: same as START.
- Transitions:
  - START -> INIT_WR -> IDLE, unconditionally.
  - IDLE -> RD_ADDR when enable & irq; otherwise stay in IDLE.
  - RD_ADDR -> RD_DATA -> CLR_WR -> APPLY -> IDLE, unconditionally.
- The slave never stalls: no waitrequest; each write completes in its single cycle.
- cap register: WIDTH bits, reset 0. Loads readdata[WIDTH-1:0] on the clock edge ending RD_DATA; upper readdata bits are ignored.
- APPLY, when cap != 0:
  - mode=0: led <= led ^ cap.
  - mode=1: led <= cap.
  - event_count <= event_count + 1, holding at 16'hFFFF.
- APPLY, when cap == 0 (spurious service): led and event_count are unchanged.
- led_clear=1 in any state: led <= 0 on that edge, overriding a coincident APPLY update. event_count is unaffected.
- Latency: irq sampled high in IDLE at cycle N gives led/event_count updated at the edge ending N+4. busy is high in cycles N+1..N+4.
- After CLR_WR the slave's edge_capture is 0, so irq is low by IDLE unless a new edge arrived. A new edge re-triggers service immediately.
- Edge lost by design: an edge landing in the same cycle as CLR_WR is dropped, because the slave's clear has priority.
- An edge captured after RD_DATA but before CLR_WR is also cleared unseen. This is an accepted limitation.
- enable deasserted mid-service: the current service completes; no new service starts.
- mode and led_clear are sampled only at their use edge.
- Reset, including mid-operation: state=START, led=0, cap=0, event_count=0, busy=1, bus outputs at START values. The INIT_MASK write is reissued after reset release.

Test Plan:
- Reset release, INIT_MASK=4'h5 -> one cycle of cs=1, wr_n=0, addr=2, wdata=32'h5 in the 2nd cycle after release; then IDLE with busy=0, led=0.
- Press button 1 on the PIO model (edge_capture=4'b0010), mode=0 -> read at addr 3, then write addr 3 with wdata=32'h2; led=4'h2, event_count=1 exactly 4 cycles after irq is seen. Second press gives led=4'h0, event_count=2.
- mode=1, led=4'hA, buttons 0 and 3 pressed together (cap=4'h9) -> led=4'h9; readdata upper bits forced to 32'hFFFF_FFF0 still give cap=4'h9.
- led_clear asserted in the APPLY cycle with cap=4'h4 -> led=0, event_count still increments.
- irq forced high with readdata=0 -> full bus sequence runs, led and event_count unchanged. enable=0 with irq high -> no bus activity.
- event_count preloaded via 65535 services (or force) -> stays at 16'hFFFF. reset_n pulsed during RD_DATA -> outputs return to reset values asynchronously, INIT write reissued.
